// File: rtl/mnist_ctrl_pkg.sv
// rtl/mnist_ctrl_pkg.sv - state encoding and default sizes for the MNIST sequencing controller
package mnist_ctrl_pkg;

   localparam int MNIST_NUM_CLASSES = 10;
   localparam int MNIST_NUM_PIXELS  = 784;
   localparam int MNIST_RD_LAT      = 2;

   typedef enum logic [2:0] {
      IDLE,
      BIAS,
      PIX,
      DRAIN,
      NEXT
   } ctrl_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - DEPTH-cycle strobe delay; o_empty means no strobe is still behind the output stage
module valid_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_valid,
   output logic o_valid,
   output logic o_empty
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic w_unused_clk_rst;
         assign w_unused_clk_rst = clk ^ rst;
         assign o_valid          = i_valid;
         assign o_empty          = 1'b1;
      end else if (DEPTH == 1) begin : g_one
         logic r_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_q <= 1'b0;
            else     r_q <= i_valid;
         end
         assign o_valid = r_q;
         assign o_empty = 1'b1;
      end else begin : g_shift
         logic [DEPTH-1:0] r_sr;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_sr <= '0;
            else     r_sr <= {r_sr[DEPTH-2:0], i_valid};
         end
         assign o_valid = r_sr[DEPTH-1];
         // The output stage is excluded so the caller can leave its drain wait one cycle early.
         assign o_empty = ~|r_sr[DEPTH-2:0];
      end
   endgenerate

endmodule

// File: rtl/mnist_seq_controller.sv
// rtl/mnist_seq_controller.sv - bias load / pixel sweep sequencer for MNIST batches; MNIST_CTRL_STALL_EN enables i_stall
module mnist_seq_controller
   import mnist_ctrl_pkg::*;
#(
   parameter int NUM_CLASSES = MNIST_NUM_CLASSES,
   parameter int NUM_PIXELS  = MNIST_NUM_PIXELS,
   parameter int ADDR_W      = 12,
   parameter int RD_LAT      = MNIST_RD_LAT,
   parameter int IMG_W       = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_start,
   input  logic [IMG_W-1:0]               i_num_images,
   input  logic                           i_stall,
   output logic [$clog2(NUM_CLASSES)-1:0] o_bias_addr,
   output logic [NUM_CLASSES-1:0]         o_bias_load,
   output logic [ADDR_W-1:0]              o_pixel_addr,
   output logic                           o_pixel_valid,
   output logic                           o_image_start,
   output logic                           o_image_done,
   output logic [IMG_W-1:0]               o_image_idx,
   output logic                           o_busy,
   output logic                           o_done
);

   localparam int BW  = $clog2(NUM_CLASSES);
   localparam int PCW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

   ctrl_state_t      r_state;
   logic [PCW-1:0]   r_pix_cnt;
   logic [IMG_W-1:0] r_count;

   logic             w_stall;
   logic             w_issue;
   logic             w_first;
   logic             w_last_pix;
   logic             w_last_img;
   logic             w_empty;
   logic             w_unused_start_empty;
   logic [IMG_W:0]   w_idx_next;

`ifdef MNIST_CTRL_STALL_EN
   assign w_stall = i_stall;
`else
   logic w_unused_stall;
   assign w_unused_stall = i_stall;
   assign w_stall        = 1'b0;
`endif

   assign w_issue    = (r_state == PIX) && !w_stall;
   assign w_first    = w_issue && (r_pix_cnt == '0);
   assign w_last_pix = (r_pix_cnt == PCW'(NUM_PIXELS - 1));
   assign w_idx_next = {1'b0, o_image_idx} + (IMG_W + 1)'(1);
   assign w_last_img = (w_idx_next >= {1'b0, r_count});

   // Image start rides its own delay line so it lines up with the first pixel_valid.
   valid_delay_line #(.DEPTH(RD_LAT)) u_valid_dl (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_issue),
      .o_valid (o_pixel_valid),
      .o_empty (w_empty)
   );

   valid_delay_line #(.DEPTH(RD_LAT)) u_start_dl (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_first),
      .o_valid (o_image_start),
      .o_empty (w_unused_start_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_pix_cnt    <= '0;
         r_count      <= '0;
         o_bias_addr  <= '0;
         o_bias_load  <= '0;
         o_pixel_addr <= '0;
         o_image_done <= 1'b0;
         o_image_idx  <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
      end else begin
         o_image_done <= 1'b0;
         o_done       <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_count      <= (i_num_images == '0) ? IMG_W'(1) : i_num_images;
                  o_pixel_addr <= '0;
                  o_image_idx  <= '0;
                  o_busy       <= 1'b1;
                  o_bias_addr  <= '0;
                  o_bias_load  <= NUM_CLASSES'(1);
                  r_state      <= BIAS;
               end
            end
            BIAS: begin
               if (o_bias_addr == BW'(NUM_CLASSES - 1)) begin
                  o_bias_load <= '0;
                  r_pix_cnt   <= '0;
                  r_state     <= PIX;
               end else begin
                  o_bias_addr <= o_bias_addr + BW'(1);
                  o_bias_load <= o_bias_load << 1;
               end
            end
            PIX: begin
               if (w_issue) begin
                  o_pixel_addr <= o_pixel_addr + ADDR_W'(1);
                  r_pix_cnt    <= r_pix_cnt + PCW'(1);
                  if (w_last_pix) begin
                     // With no read latency there is nothing to drain.
                     if (RD_LAT == 0) begin
                        r_state      <= NEXT;
                        o_image_done <= 1'b1;
                        o_done       <= w_last_img;
                     end else begin
                        r_state <= DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               if (w_empty) begin
                  r_state      <= NEXT;
                  o_image_done <= 1'b1;
                  o_done       <= w_last_img;
               end
            end
            NEXT: begin
               if (o_done) begin
                  r_state <= IDLE;
                  o_busy  <= 1'b0;
               end else begin
                  o_image_idx <= o_image_idx + IMG_W'(1);
                  o_bias_addr <= '0;
                  o_bias_load <= NUM_CLASSES'(1);
                  r_state     <= BIAS;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mnist_seq_controller.sv
// tb/tb_mnist_seq_controller.sv - table-driven and randomized runs checked against a per-cycle schedule model
module tb_mnist_seq_controller;

   localparam int NC   = 4;
   localparam int NP   = 8;
   localparam int RL   = 2;
   localparam int AW   = 5;
   localparam int IW   = 8;
   localparam int MAXC = 1024;
`ifdef MNIST_CTRL_STALL_EN
   localparam bit STALL_ON = 1'b1;
`else
   localparam bit STALL_ON = 1'b0;
`endif

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          i_start = 1'b0;
   logic          i_stall = 1'b0;
   logic [IW-1:0] i_num   = '0;
   logic [1:0]    o_bias_addr;
   logic [NC-1:0] o_bias_load;
   logic [AW-1:0] o_pixel_addr;
   logic          o_pixel_valid, o_image_start, o_image_done;
   logic [IW-1:0] o_image_idx;
   logic          o_busy, o_done;

   int n_vec = 0;
   int n_err = 0;

   int e_bl[MAXC], e_ba[MAXC], e_addr[MAXC], e_pv[MAXC], e_is[MAXC];
   int e_id[MAXC], e_idx[MAXC], e_busy[MAXC], e_done[MAXC];
   bit e_in_bias[MAXC];
   bit stall_pat[MAXC];
   int e_len;

   typedef struct {
      int num;
      int start_at;
      int stall_mode;
      int exp_done;
   } vec_t;
   vec_t tbl[5];

   always #5 clk = ~clk;

   mnist_seq_controller #(
      .NUM_CLASSES (NC),
      .NUM_PIXELS  (NP),
      .ADDR_W      (AW),
      .RD_LAT      (RL),
      .IMG_W       (IW)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_num_images  (i_num),
      .i_stall       (i_stall),
      .o_bias_addr   (o_bias_addr),
      .o_bias_load   (o_bias_load),
      .o_pixel_addr  (o_pixel_addr),
      .o_pixel_valid (o_pixel_valid),
      .o_image_start (o_image_start),
      .o_image_done  (o_image_done),
      .o_image_idx   (o_image_idx),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   task automatic chk(input string nm, input int t, input logic [31:0] act, input int exp);
      n_vec++;
      if (act !== 32'(exp)) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, t, act, exp);
      end
   endtask

   task automatic chk_zero(input int t);
      chk("rst_bias_addr", t, 32'(o_bias_addr), 0);
      chk("rst_bias_load", t, 32'(o_bias_load), 0);
      chk("rst_pixel_addr", t, 32'(o_pixel_addr), 0);
      chk("rst_pixel_valid", t, 32'(o_pixel_valid), 0);
      chk("rst_image_start", t, 32'(o_image_start), 0);
      chk("rst_image_done", t, 32'(o_image_done), 0);
      chk("rst_image_idx", t, 32'(o_image_idx), 0);
      chk("rst_busy", t, 32'(o_busy), 0);
      chk("rst_done", t, 32'(o_done), 0);
   endtask

   task automatic mark(input int t, input int img, input int a);
      e_busy[t] = 1;
      e_idx[t]  = img;
      e_addr[t] = a % (1 << AW);
   endtask

   // Schedule per image: NC bias cycles, NP issues (skipping stalled cycles), RL drain, one done cycle.
   task automatic build_model(input int num);
      int n_img, t, k;
      n_img = (num == 0) ? 1 : num;
      for (int i = 0; i < MAXC; i++) begin
         e_bl[i] = 0; e_ba[i] = 0; e_addr[i] = 0; e_pv[i] = 0; e_is[i] = 0;
         e_id[i] = 0; e_idx[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_in_bias[i] = 1'b0;
      end
      t = 1;
      for (int img = 0; img < n_img; img++) begin
         for (int c = 0; c < NC; c++) begin
            e_bl[t] = 1 << c;
            e_ba[t] = c;
            e_in_bias[t] = 1'b1;
            mark(t, img, img * NP);
            t++;
         end
         k = 0;
         while (k < NP && t < MAXC - RL - 4) begin
            mark(t, img, img * NP + k);
            if (!(STALL_ON && stall_pat[t])) begin
               e_pv[t + RL] = 1;
               if (k == 0) e_is[t + RL] = 1;
               k++;
            end
            t++;
         end
         for (int d = 0; d <= RL; d++) begin
            mark(t, img, (img + 1) * NP);
            t++;
         end
         e_id[t - 1] = 1;
         if (img == n_img - 1) e_done[t - 1] = 1;
      end
      e_len = t;
      e_idx[t]  = n_img - 1;
      e_addr[t] = (n_img * NP) % (1 << AW);
   endtask

   task automatic check_cycle(input int t);
      chk("bias_load", t, 32'(o_bias_load), e_bl[t]);
      if (e_in_bias[t]) chk("bias_addr", t, 32'(o_bias_addr), e_ba[t]);
      chk("pixel_addr", t, 32'(o_pixel_addr), e_addr[t]);
      chk("pixel_valid", t, 32'(o_pixel_valid), e_pv[t]);
      chk("image_start", t, 32'(o_image_start), e_is[t]);
      chk("image_done", t, 32'(o_image_done), e_id[t]);
      chk("image_idx", t, 32'(o_image_idx), e_idx[t]);
      chk("busy", t, 32'(o_busy), e_busy[t]);
      chk("done", t, 32'(o_done), e_done[t]);
   endtask

   // Call right after a posedge; returns the cycle in which done was first seen (-1 if never).
   task automatic do_run(input int num, input int start_at, input int mode, output int done_cyc);
      for (int i = 0; i < MAXC; i++)
         stall_pat[i] = (mode == 1) ? ($urandom_range(3) == 0) : (mode == 2 && (i == 7 || i == 8));
      build_model(num);
      done_cyc = -1;
      #1;
      i_start = 1'b1;
      i_num   = num[IW-1:0];
      i_stall = 1'b0;
      @(posedge clk);
      for (int t = 1; t <= e_len; t++) begin
         #1;
         i_start = (t == start_at);
         i_num   = IW'($urandom);
         i_stall = stall_pat[t];
         @(negedge clk);
         check_cycle(t);
         if (o_done === 1'b1 && done_cyc < 0) done_cyc = t;
         @(posedge clk);
      end
      #1;
      i_start = 1'b0;
      i_stall = 1'b0;
   endtask

   initial begin
      int dc;
      int num;
      tbl[0] = '{num: 1, start_at: 0, stall_mode: 0, exp_done: 15};
      tbl[1] = '{num: 2, start_at: 6, stall_mode: 0, exp_done: 30};
      tbl[2] = '{num: 0, start_at: 6, stall_mode: 0, exp_done: 15};
      tbl[3] = '{num: 5, start_at: 0, stall_mode: 0, exp_done: 75};
      tbl[4] = '{num: 1, start_at: 0, stall_mode: 2, exp_done: STALL_ON ? 17 : 15};

      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk_zero(c);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk_zero(100 + c);
      end
      @(posedge clk);

      for (int i = 0; i < 5; i++) begin
         do_run(tbl[i].num, tbl[i].start_at, tbl[i].stall_mode, dc);
         chk("done_cycle_tbl", i, 32'(dc), tbl[i].exp_done);
         @(posedge clk);
      end

      // Asynchronous reset in the middle of the first image's pixel sweep.
      #1;
      i_start = 1'b1;
      i_num   = 8'd2;
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("midrun_busy", 9, 32'(o_busy), 1);
      chk("midrun_pixel_addr", 9, 32'(o_pixel_addr), 4);
      #1 rst = 1'b1;
      #1 chk_zero(9);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      do_run(1, 0, 0, dc);
      chk("done_cycle_after_rst", 0, 32'(dc), 15);
      @(posedge clk);

      for (int r = 0; r < 8; r++) begin
         num = $urandom_range(6);
         do_run(num, $urandom_range(10, 2), 1, dc);
         chk("done_cycle_rand", r, 32'(dc), e_len - 1);
         @(posedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mnist_seq_controller.md
# mnist_seq_controller

Parametrised sequencing controller for the MNIST inference datapath. For each image in a run it loads the neuron biases one class at a time, then sweeps pixel ROM addresses. It delays a read-valid strobe to match the ROM/MAC read latency, then signals per-image and per-run completion. It sits between the top-level run control and the pixel ROM, bias ROM and per-class accumulators, and supports multi-image batches and a start/busy/done handshake.

## Interface
- NUM_CLASSES, 10: number of output neurons / bias words (≥2)
- NUM_PIXELS, 784: pixels per image (≥1)
- ADDR_W, 12: pixel address width; global address wraps modulo 2^ADDR_W
- RD_LAT, 2: pixel read latency in cycles (0 allowed)
- IMG_W, 8: image count/index width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request, sampled only in IDLE
- num_images  in  IMG_W  images per run, sampled with start; 0 treated as 1
- stall  in  1  pause pixel issue (only effective with MNIST_CTRL_STALL_EN)
- bias_addr  out  clog2(NUM_CLASSES)  bias ROM address
- bias_load  out  NUM_CLASSES  one-hot accumulator bias-load strobe
- pixel_addr  out  ADDR_W  global pixel ROM address
- pixel_valid  out  1  pixel data valid at ROM/MAC output
- image_start  out  1  pulse with first pixel_valid of each image
- image_done  out  1  pulse after last pixel_valid of each image
- image_idx  out  IMG_W  index of image in progress
- busy  out  1  run in progress
- done  out  1  run-complete pulse

## Operation
- All outputs registered. Reset value of every output is 0.
- States: IDLE, BIAS, PIX, DRAIN, NEXT.
- IDLE:
  - start=1 captures num_images and zeroes pixel_addr and image_idx.
  - Next state is BIAS; busy rises.
- BIAS: one cycle per class.
  - bias_addr = c; bias_load = 1<<c for c = 0..NUM_CLASSES-1.
  - After the last class, bias_load returns to 0 and the state goes to PIX.
- PIX: issues NUM_PIXELS reads.
  - Issue k presents pixel_addr = base+k.
  - The issue strobe enters an RD_LAT-deep delay line whose output is pixel_valid.
  - After the last issue, pixel_addr holds base+NUM_PIXELS, which is the next image's base. The state goes to DRAIN.
- DRAIN: waits until the delay line is empty.
- NEXT: one cycle.
  - image_done=1.
  - If image_idx+1 ≥ captured count: done=1, then go to IDLE (busy falls next cycle).
  - Otherwise image_idx increments and the state goes to BIAS.
- start while busy is ignored. rst mid-run returns all state and outputs to reset values immediately.
- Per-image pixel count is exact: a counter compares against NUM_PIXELS-1. pixel_addr is never compared.

## Timing
- start sampled at edge E0; cycles after E0 are numbered from 1.
- Per image, with cycle 1 being the start of that image:
  - BIAS: cycles 1..NUM_CLASSES.
  - Issue: cycles NUM_CLASSES+1..NUM_CLASSES+NUM_PIXELS.
  - pixel_valid: issue cycle + RD_LAT.
  - image_done: cycle NUM_CLASSES+NUM_PIXELS+RD_LAT+1.
- Image period P = NUM_CLASSES+NUM_PIXELS+RD_LAT+1. Image n+1 BIAS starts the cycle after image n's image_done.
- done coincides with the last image_done. busy is high from cycle 1 through the done cycle.
- The first start is accepted the cycle after busy falls.

## Configuration
- MNIST_CTRL_STALL_EN defined:
  - stall=1 in PIX suppresses issue and holds pixel_addr and the pixel counter.
  - The delay line keeps shifting with 0 inserted, so in-flight reads still retire and pixel_valid gaps appear.
  - stall is ignored in all other states.
- MNIST_CTRL_STALL_EN undefined: the stall port exists but is ignored; pixel_valid is contiguous.

## Structure
- Package mnist_ctrl_pkg holds:
  - the state enum;
  - default constants MNIST_NUM_CLASSES=10, MNIST_NUM_PIXELS=784, MNIST_RD_LAT=2.
- Sub-module valid_delay_line #(DEPTH): shift register with a registered output and an empty flag. DEPTH=0 is a combinational passthrough with empty always 1.

## Test plan
All tests use NUM_CLASSES=4, NUM_PIXELS=8, RD_LAT=2 unless noted.
- Reset, hold 5 cycles, start=0 -> every output stays 0; state IDLE.
- start with num_images=1 ->
  - bias_load 0001,0010,0100,1000 in cycles 1-4;
  - pixel_addr 0..7 issued in cycles 5-12;
  - pixel_valid in cycles 7-14; image_start in cycle 7;
  - image_done and done in cycle 15; busy low in cycle 16.
- start with num_images=2 ->
  - second BIAS in cycles 16-19;
  - pixel_addr 8..15 in cycles 20-27;
  - image_idx=1 from cycle 16;
  - done only in cycle 30.
- num_images=0 -> behaves exactly as num_images=1. start pulsed at cycle 6 -> ignored.
- rst asserted at cycle 9 -> all outputs 0 in the same cycle. A new start gives a clean run from pixel_addr 0.
- With MNIST_CTRL_STALL_EN, stall high for cycles 7-8 ->
  - issue is deferred 2 cycles and addresses 0..7 are unbroken;
  - pixel_valid has a 2-cycle gap;
  - image_done moves to cycle 17. RD_LAT=0 variant: pixel_valid coincides with issue.
